dot_scroll_ctrl: RTL

- Parametrised scrolling-message engine for the LED dot-matrix panel.
- Message columns are held in a writable column memory, not hard-wired constants.
- Each step shifts one column into a COLS-wide frame, from either side, at a runtime-selectable rate; loop or one-shot mode.
- The frame bus feeds the existing column-scan display driver; the block replaces fixed-text scrollers.

---
 rtl/dot_scroll_ctrl_pkg.sv | 19 +
 rtl/dot_step_prescaler.sv | 36 +++
 rtl/dot_scroll_ctrl.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/dot_scroll_ctrl_pkg.sv
// rtl/dot_scroll_ctrl_pkg.sv - shared types and helpers for the dot-matrix scroller
package dot_scroll_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    // Shift direction: LEFT inserts at the highest column, RIGHT at column 0.
    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    // Lowest bit of column 'col' in a frame bus of 'rows'-bit columns.
    function automatic int col_lsb(input int col, input int rows);
        return col * rows;
    endfunction

endpackage

// File: rtl/dot_step_prescaler.sv
// rtl/dot_step_prescaler.sv - step-rate prescaler with >= compare
module dot_step_prescaler #(
    parameter int SPW = 16
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           en,
    input  logic           clr,
    input  logic [SPW-1:0] speed,
    output logic           tick
);

    logic [SPW-1:0] cnt_q;
    logic [SPW-1:0] cnt_d;

    // Tick once the count reaches or passes the period, so lowering speed never strands the counter.
    always_comb begin
        tick  = en && (cnt_q >= speed);
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dot_scroll_ctrl.sv
// rtl/dot_scroll_ctrl.sv - scrolling-message engine for the LED dot-matrix panel
module dot_scroll_ctrl
    import dot_scroll_ctrl_pkg::*;
#(
    parameter int COLS  = 10,
    parameter int ROWS  = 7,
    parameter int DEPTH = 64,
    parameter int AW    = 6,
    parameter int SPW   = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic [AW-1:0]        wr_addr,
    input  logic [ROWS-1:0]      wr_data,
    input  logic [AW:0]          msg_len,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 dir,
    input  logic                 loop_en,
    input  logic [SPW-1:0]       speed,
    output logic [COLS*ROWS-1:0] frame,
    output logic                 step,
    output logic                 busy,
    output logic                 done
);

    localparam int              FW         = COLS * ROWS;
    localparam int              CW         = $clog2(COLS + 1);
    localparam logic [AW:0]     DEPTH_W    = (AW+1)'(DEPTH);
    localparam logic [CW-1:0]   FLUSH_LAST = CW'(COLS - 1);

    logic [ROWS-1:0] mem_q [DEPTH];

    state_t          state_q, state_d;
    logic [AW-1:0]   ptr_q, ptr_d;
    logic [CW-1:0]   flush_q, flush_d;
    logic [FW-1:0]   frame_q, frame_d;
    logic            step_q, step_d;
    logic            done_q, done_d;

    logic [FW-1:0]   shifted;
    logic [AW:0]     len_eff;
    logic [AW:0]     ptr_inc;
    logic [ROWS-1:0] insert;
    logic            tick, pre_en, go, adv, at_end, flush_end;

    assign len_eff = (msg_len > DEPTH_W) ? DEPTH_W : msg_len;
    assign ptr_inc = {1'b0, ptr_q} + 1'b1;

    dot_step_prescaler #(.SPW(SPW)) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .en    (pre_en),
        .clr   (!pre_en),
        .speed (speed),
        .tick  (tick)
    );

    // Message memory: writes beyond DEPTH are dropped; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en && ({1'b0, wr_addr} < DEPTH_W)) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; stop always wins over start and over a pending tick.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (go) state_d = ST_RUN;
            ST_RUN: begin
                if (stop)                             state_d = ST_IDLE;
                else if (adv && at_end && !loop_en)   state_d = ST_FLUSH;
            end
            ST_FLUSH: begin
                if (stop)                             state_d = ST_IDLE;
                else if (adv && flush_end)            state_d = ST_IDLE;
            end
            default:                                  state_d = ST_IDLE;
        endcase
    end

    // FSM outputs and control decode; the read at ptr is combinational.
    always_comb begin
        pre_en    = (state_q != ST_IDLE);
        busy      = pre_en;
        go        = (state_q == ST_IDLE) && start && !stop && (len_eff != '0);
        adv       = pre_en && !stop && tick;
        at_end    = (ptr_inc >= len_eff);
        flush_end = (flush_q == FLUSH_LAST);
        insert    = (state_q == ST_RUN) ? mem_q[ptr_q] : '0;
    end

    // Frame shifted by one column with the insert column entering on the chosen side.
    always_comb begin
        shifted = frame_q;
        if (dir == DIR_LEFT) begin
            for (int i = 0; i < COLS - 1; i++) begin
                shifted[col_lsb(i, ROWS) +: ROWS] = frame_q[col_lsb(i + 1, ROWS) +: ROWS];
            end
            shifted[col_lsb(COLS - 1, ROWS) +: ROWS] = insert;
        end else begin
            for (int i = 1; i < COLS; i++) begin
                shifted[col_lsb(i, ROWS) +: ROWS] = frame_q[col_lsb(i - 1, ROWS) +: ROWS];
            end
            shifted[col_lsb(0, ROWS) +: ROWS] = insert;
        end
    end

    // Datapath next values: start clears, each tick shifts and advances ptr or flush count.
    always_comb begin
        frame_d = frame_q;
        ptr_d   = ptr_q;
        flush_d = flush_q;
        step_d  = 1'b0;
        done_d  = 1'b0;
        if (go) begin
            frame_d = '0;
            ptr_d   = '0;
            flush_d = '0;
        end else if (adv) begin
            frame_d = shifted;
            step_d  = 1'b1;
            if (state_q == ST_RUN) begin
                if (!at_end) begin
                    ptr_d = ptr_q + 1'b1;
                end else begin
                    ptr_d   = '0;
                    flush_d = '0;
                end
            end else begin
                flush_d = flush_q + 1'b1;
                done_d  = flush_end;
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_q <= '0;
            ptr_q   <= '0;
            flush_q <= '0;
            step_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            frame_q <= frame_d;
            ptr_q   <= ptr_d;
            flush_q <= flush_d;
            step_q  <= step_d;
            done_q  <= done_d;
        end
    end

    assign frame = frame_q;
    assign step  = step_q;
    assign done  = done_q;

endmodule
